// File: rtl/multi_reaction_timer_pkg.sv
// Shared types and constants for the multi-player reaction timer.
package multi_reaction_timer_pkg;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_RAND = 2'd1,
        S_ARMED     = 2'd2,
        S_REPORT    = 2'd3
    } state_t;

    localparam logic [7:0] LED_ON = 8'hFF;
    localparam int         PIDX_W = 3;

endpackage

// File: rtl/multi_reaction_timer_player_channel.sv
// One player's channel: button edge detect, captured time and done/cheat/slow flags.
module rt_player_channel
    import multi_reaction_timer_pkg::*;
#(
    parameter int TIME_W     = 10,
    parameter int TIMEOUT_MS = 999
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  state_t            i_state,
    input  logic [TIME_W-1:0] i_ms,
    input  logic              i_tick,
    input  logic              i_btn,
    input  logic              i_clear,
    output logic [TIME_W-1:0] o_time,
    output logic              o_done,
    output logic              o_cheat,
    output logic              o_slow
);

    logic              r_btn_q;
    logic [TIME_W-1:0] r_time;
    logic              r_done;
    logic              r_cheat;
    logic              r_slow;
    logic              w_rise;
    logic              w_timeout;

    assign w_rise    = i_btn & ~r_btn_q;
    assign w_timeout = (i_state == S_ARMED) && i_tick && (i_ms == TIME_W'(TIMEOUT_MS));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_btn_q <= 1'b0;
            r_time  <= '0;
            r_done  <= 1'b0;
            r_cheat <= 1'b0;
            r_slow  <= 1'b0;
        end else begin
            r_btn_q <= i_btn;
            if (i_clear) begin
                r_time  <= '0;
                r_done  <= 1'b0;
                r_cheat <= 1'b0;
                r_slow  <= 1'b0;
            end else if (i_state == S_WAIT_RAND) begin
                if (w_rise) r_cheat <= 1'b1;
            end else if ((i_state == S_ARMED) && !r_cheat && !r_done) begin
                // A press on the timeout tick still counts as a real capture.
                if (w_rise) begin
                    r_time <= i_ms;
                    r_done <= 1'b1;
                end else if (w_timeout) begin
                    r_time <= TIME_W'(TIMEOUT_MS);
                    r_slow <= 1'b1;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign o_time  = r_time;
    assign o_done  = r_done;
    assign o_cheat = r_cheat;
    assign o_slow  = r_slow;

endmodule

// File: rtl/multi_reaction_timer.sv
// N-player reaction timer: random wait, armed LED, per-player capture, winner report.
// Optional best-time record enabled by the BEST_TIME_EN macro.
//
// state     | meaning
// IDLE      | results held, waiting for Start rise
// WAIT_RAND | counting down the random delay; presses mark cheaters
// ARMED     | LED lit, ms counter running, capturing presses
// REPORT    | LCDUpdate held until LCDAck
module multi_reaction_timer
    import multi_reaction_timer_pkg::*;
#(
    parameter int NUM_PLAYERS  = 2,
    parameter int TIME_W       = 10,
    parameter int RAND_W       = 13,
    parameter int MIN_DELAY_MS = 1000,
    parameter int TIMEOUT_MS   = 999
) (
    input  logic                          i_Clk,
    input  logic                          i_Rst,
    input  logic                          i_TickMS,
    input  logic                          i_Start,
    input  logic [NUM_PLAYERS-1:0]        i_Btn,
    input  logic [RAND_W-1:0]             i_RandomValue,
    output logic [7:0]                    o_LED,
    output logic [NUM_PLAYERS*TIME_W-1:0] o_ReactionTime,
    output logic [NUM_PLAYERS-1:0]        o_Cheat,
    output logic [NUM_PLAYERS-1:0]        o_Slow,
    output logic [PIDX_W-1:0]             o_Winner,
    output logic                          o_WinValid,
    output logic                          o_Wait,
    output logic                          o_LCDUpdate,
`ifdef BEST_TIME_EN
    output logic [TIME_W-1:0]             o_BestTime,
    output logic [PIDX_W-1:0]             o_BestPlayer,
`endif
    input  logic                          i_LCDAck
);

    localparam logic [RAND_W:0] DLY_MIN = (RAND_W+1)'(MIN_DELAY_MS);
    localparam logic [RAND_W:0] DLY_ONE = (RAND_W+1)'(1);

    state_t                         r_state;
    state_t                         w_state_nxt;
    logic                           r_start_q;
    logic [RAND_W:0]                r_delay;
    logic [TIME_W-1:0]              r_ms;
    logic                           r_show;
    logic                           w_start_rise;
    logic                           w_clear;
    logic                           w_dly_tc;
    logic                           w_timeout;
    logic                           w_all_done;
    logic [NUM_PLAYERS*TIME_W-1:0]  w_times;
    logic [NUM_PLAYERS-1:0]         w_done;
    logic [NUM_PLAYERS-1:0]         w_cheat;
    logic [NUM_PLAYERS-1:0]         w_slow;
    logic [PIDX_W-1:0]              w_winner;
    logic [TIME_W-1:0]              w_win_time;
    logic                           w_win_valid;

    assign w_start_rise = i_Start & ~r_start_q;
    assign w_clear      = (r_state == S_IDLE) && w_start_rise;
    assign w_dly_tc     = (r_delay <= DLY_ONE);
    assign w_timeout    = (r_state == S_ARMED) && i_TickMS && (r_ms == TIME_W'(TIMEOUT_MS));
    assign w_all_done   = &(w_done | w_cheat);

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:      if (w_start_rise) w_state_nxt = S_WAIT_RAND;
            S_WAIT_RAND: begin
                if (&w_cheat)                 w_state_nxt = S_REPORT;
                else if (i_TickMS && w_dly_tc) w_state_nxt = S_ARMED;
            end
            S_ARMED:     if (w_all_done || w_timeout) w_state_nxt = S_REPORT;
            S_REPORT:    if (i_LCDAck) w_state_nxt = S_IDLE;
            default:     w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_start_q <= 1'b0;
            r_delay   <= '0;
            r_ms      <= '0;
            r_show    <= 1'b0;
        end else begin
            r_start_q <= i_Start;
            if (w_clear)
                r_delay <= DLY_MIN + {1'b0, i_RandomValue};
            else if ((r_state == S_WAIT_RAND) && i_TickMS)
                r_delay <= w_dly_tc ? '0 : r_delay - DLY_ONE;

            if ((r_state == S_WAIT_RAND) && (w_state_nxt == S_ARMED))
                r_ms <= '0;
            else if ((r_state == S_ARMED) && i_TickMS && !w_timeout)
                r_ms <= r_ms + TIME_W'(1);

            // Winner outputs stay visible from REPORT entry until the next round starts.
            if (w_clear)                        r_show <= 1'b0;
            else if (w_state_nxt == S_REPORT)   r_show <= 1'b1;
        end
    end

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_ch
        rt_player_channel #(
            .TIME_W     (TIME_W),
            .TIMEOUT_MS (TIMEOUT_MS)
        ) u_ch (
            .i_clk   (i_Clk),
            .i_rst   (i_Rst),
            .i_state (r_state),
            .i_ms    (r_ms),
            .i_tick  (i_TickMS),
            .i_btn   (i_Btn[p]),
            .i_clear (w_clear),
            .o_time  (w_times[p*TIME_W +: TIME_W]),
            .o_done  (w_done[p]),
            .o_cheat (w_cheat[p]),
            .o_slow  (w_slow[p])
        );
    end

    // Strict less-than keeps the lowest index on ties.
    always_comb begin
        w_win_valid = 1'b0;
        w_winner    = '0;
        w_win_time  = '1;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (w_done[p] && !w_cheat[p] && !w_slow[p] &&
                (!w_win_valid || (w_times[p*TIME_W +: TIME_W] < w_win_time))) begin
                w_win_valid = 1'b1;
                w_winner    = PIDX_W'(p);
                w_win_time  = w_times[p*TIME_W +: TIME_W];
            end
        end
    end

`ifdef BEST_TIME_EN
    logic [TIME_W-1:0] r_best_time;
    logic [PIDX_W-1:0] r_best_player;

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_best_time   <= '1;
            r_best_player <= '0;
        end else if ((r_state == S_REPORT) && w_win_valid && (w_win_time < r_best_time)) begin
            r_best_time   <= w_win_time;
            r_best_player <= w_winner;
        end
    end

    assign o_BestTime   = r_best_time;
    assign o_BestPlayer = r_best_player;
`endif

    assign o_LED          = (r_state == S_ARMED) ? LED_ON : 8'h00;
    assign o_Wait         = (r_state == S_WAIT_RAND);
    assign o_LCDUpdate    = (r_state == S_REPORT);
    assign o_ReactionTime = w_times;
    assign o_Cheat        = w_cheat;
    assign o_Slow         = w_slow;
    assign o_Winner       = r_show ? w_winner : '0;
    assign o_WinValid     = r_show & w_win_valid;

endmodule

// File: tb/tb_multi_reaction_timer.sv
// Scoreboard bench for multi_reaction_timer (2 players, 10 ms minimum delay).
module tb_multi_reaction_timer;

    localparam int NP   = 2;
    localparam int TW   = 10;
    localparam int RW   = 13;
    localparam int MIND = 10;
    localparam int TMO  = 999;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            tick = 1'b0;
    logic            start = 1'b0;
    logic [NP-1:0]   btn = '0;
    logic [RW-1:0]   rnd = '0;
    logic            ack = 1'b0;
    logic [7:0]      led;
    logic [NP*TW-1:0] rt;
    logic [NP-1:0]   cheat;
    logic [NP-1:0]   slow;
    logic [2:0]      winner;
    logic            win_valid;
    logic            wait_o;
    logic            lcd;
`ifdef BEST_TIME_EN
    logic [TW-1:0]   best_time;
    logic [2:0]      best_player;
`endif

    typedef struct {
        int rt0; int rt1; int cheat; int slow;
        int winner; int winvalid; int best; int bestp;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    int   best_m = (1 << TW) - 1;
    int   best_p = 0;

    multi_reaction_timer #(
        .NUM_PLAYERS  (NP),
        .TIME_W       (TW),
        .RAND_W       (RW),
        .MIN_DELAY_MS (MIND),
        .TIMEOUT_MS   (TMO)
    ) dut (
        .i_Clk          (clk),
        .i_Rst          (rst),
        .i_TickMS       (tick),
        .i_Start        (start),
        .i_Btn          (btn),
        .i_RandomValue  (rnd),
        .o_LED          (led),
        .o_ReactionTime (rt),
        .o_Cheat        (cheat),
        .o_Slow         (slow),
        .o_Winner       (winner),
        .o_WinValid     (win_valid),
        .o_Wait         (wait_o),
        .o_LCDUpdate    (lcd),
`ifdef BEST_TIME_EN
        .o_BestTime     (best_time),
        .o_BestPlayer   (best_player),
`endif
        .i_LCDAck       (ack)
    );

    always #5 clk = ~clk;

    // Tick every 4th cycle, so the cycle right after a tick never carries one.
    initial forever begin
        @(negedge clk);
        cyc++;
        tick = (cyc % 4 == 0);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic chk_idle_zero(input string pfx);
        chk({pfx, "_led"},   led, 0);
        chk({pfx, "_rt"},    rt, 0);
        chk({pfx, "_cheat"}, cheat, 0);
        chk({pfx, "_slow"},  slow, 0);
        chk({pfx, "_win"},   {winner, win_valid}, 0);
        chk({pfx, "_wait"},  wait_o, 0);
        chk({pfx, "_lcd"},   lcd, 0);
`ifdef BEST_TIME_EN
        chk({pfx, "_best"},  best_time, (1 << TW) - 1);
        chk({pfx, "_bestp"}, best_player, 0);
`endif
    endtask

    // t = capture ms, -1 = never presses, -2 = presses during the random wait.
    task automatic round(input int t0, input int t1, input int rv);
        int t[NP];
        int rtx[NP];
        exp_t e;
        logic [NP-1:0] cm;
        logic [NP-1:0] mask;
        int wt, cnt, m, maxt;
        bit pressed, seen, got_lcd;
        t[0] = t0; t[1] = t1;
        e.cheat = 0; e.slow = 0; e.winner = 0; e.winvalid = 0; wt = 0; cm = '0; maxt = -1;
        for (int p = 0; p < NP; p++) begin
            if (t[p] == -2) begin
                e.cheat |= (1 << p); rtx[p] = 0; cm[p] = 1'b1;
            end else if (t[p] == -1) begin
                e.slow |= (1 << p); rtx[p] = TMO;
            end else begin
                rtx[p] = t[p];
                if (t[p] > maxt) maxt = t[p];
                if (!e.winvalid || t[p] < wt) begin
                    e.winvalid = 1; e.winner = p; wt = t[p];
                end
            end
        end
        if (e.winvalid && wt < best_m) begin best_m = wt; best_p = e.winner; end
        e.rt0 = rtx[0]; e.rt1 = rtx[1]; e.best = best_m; e.bestp = best_p;
        sbq.push_back(e);

        rnd = RW'(rv);
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        cnt = 0; pressed = 0; seen = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(posedge clk);
            if (tick) cnt++;
            @(negedge clk);
            if (i == 0) chk("wait_flag", wait_o, 1);
            if (i == 1) start = 1'b0;
            if (!pressed && cnt >= 2) begin btn = cm; pressed = 1; end
            else btn = '0;
            if (led == 8'hFF) seen = 1;
            if (lcd && (&cm)) seen = 1;
        end
        start = 1'b0; btn = '0;

        if (!(&cm)) begin
            chk("armed", seen, 1);
            chk("delay", cnt, MIND + rv);
            m = 0;
            while (seen && m <= maxt + 3) begin
                mask = '0;
                for (int p = 0; p < NP; p++)
                    if (t[p] == m || (t[p] >= 0 && t[p] + 3 == m) || (t[p] == -2 && m == 5))
                        mask[p] = 1'b1;
                if (mask != '0) begin btn = mask; @(negedge clk); btn = '0; end
                if (m == 2) start = 1'b1;
                if (m == 3) start = 1'b0;
                @(posedge clk);
                while (!tick) @(posedge clk);
                m++;
                @(negedge clk);
            end
            start = 1'b0;
        end

        got_lcd = 0;
        for (int k = 0; k < 6000 && !got_lcd; k++) begin
            if (lcd) got_lcd = 1;
            else @(negedge clk);
        end
        chk("lcd_rise", got_lcd, 1);
        if (got_lcd) begin
            e = sbq.pop_front();
            chk("rt0", rt[TW-1:0], e.rt0);
            chk("rt1", rt[2*TW-1:TW], e.rt1);
            chk("cheat", cheat, e.cheat);
            chk("slow", slow, e.slow);
            chk("winner", winner, e.winner);
            chk("win_valid", win_valid, e.winvalid);
            chk("led_report", led, 0);
            repeat (3) @(negedge clk);
            chk("lcd_hold", lcd, 1);
`ifdef BEST_TIME_EN
            chk("best_time", best_time, e.best);
            chk("best_player", best_player, e.bestp);
`endif
            ack = 1'b1;
            @(negedge clk);
            ack = 1'b0;
            chk("lcd_drop", lcd, 0);
            chk("hold_rt1", rt[2*TW-1:TW], e.rt1);
            chk("hold_win", {winner, win_valid}, {e.winner[2:0], e.winvalid[0]});
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic reset_mid_armed();
        bit seen, lcd_seen;
        rnd = RW'(3);
        @(negedge clk) start = 1'b1;
        @(negedge clk);
        @(negedge clk) start = 1'b0;
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (led == 8'hFF) seen = 1;
        end
        chk("rst_armed", seen, 1);
        repeat (2) begin @(posedge clk); while (!tick) @(posedge clk); end
        @(negedge clk) btn = 2'b01;
        @(negedge clk) btn = '0;
        repeat (3) begin @(posedge clk); while (!tick) @(posedge clk); end
        chk("pre_rst_rt0", rt[TW-1:0], 2);
        @(negedge clk) rst = 1'b1;
        #1;
        best_m = (1 << TW) - 1; best_p = 0;
        chk_idle_zero("midrst");
        @(negedge clk) rst = 1'b0;
        lcd_seen = 0;
        repeat (20) begin @(negedge clk); if (lcd || led != 0) lcd_seen = 1; end
        chk("midrst_quiet", lcd_seen, 0);
    endtask

    initial begin
        #12;
        chk_idle_zero("reset");
        @(negedge clk) rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_idle_lcd", lcd, 0);

        round(20, 35, 5);
        round(40, -2, 7);
        round(-1, -1, 0);
        round(17, 17, 3);
        round(-2, -2, 4);
        round(30, 12, 9);
        reset_mid_armed();
        round(50, 70, 2);
        round(45, 30, 11);
        round(40, 60, 6);

        chk("sb_empty", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
